coin_acceptor: RTL and testbench

Front-end coin acceptor that converts three raw, asynchronous coin-sensor lines into the 2-bit `coin_in` code stream consumed by the vending machine FSM. It synchronises, debounces and qualifies each coin, then emits exactly one single-cycle code per accepted coin, with mandatory idle spacing between codes. Coins that are too short, overlap another sensor, or jam a sensor are never emitted as codes. The block sits between the coin-mech sensors and the vending machine's `coin_in` port, on the same clock.

---
 rtl/coin_acceptor.sv | 172 +++++++++++++++++
 tb/tb_coin_acceptor.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: synchronises three raw coin sensors, debounces and
// qualifies each coin, and emits one single-cycle 2-bit code per accepted coin
// with idle spacing after it. Short, overlapping and jammed coins are never emitted.
module coin_acceptor #(
    parameter int DEBOUNCE  = 4,   // synchronised-high samples needed to qualify (>= 2)
    parameter int MAX_PULSE = 64,  // sample count at which a held sensor is jammed (> DEBOUNCE)
    parameter int GAP       = 2    // idle cycles of coin_out == 0 after every code (>= 1)
) (
    input  logic       clk,
    input  logic       rst,          // asynchronous, active-low
    input  logic       sense_a,
    input  logic       sense_b,
    input  logic       sense_c,
    output logic [1:0] coin_out,
    output logic       reject,
    output logic       jam,
    output logic [7:0] coin_count
);

    // One counter serves both the qualification/jam count and the GAP count.
    localparam int CNT_W = $clog2(MAX_PULSE + GAP + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LIM = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] JAM_LIM = CNT_W'(MAX_PULSE);
    localparam logic [CNT_W-1:0] GAP_LIM = CNT_W'(GAP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_QUAL,
        S_HOLD,
        S_EMIT,
        S_GAP,
        S_CLEAR,
        S_JAM
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       sel_q, sel_d;        // one-hot mask of the sensor being qualified
    logic [1:0]       coin_out_q, coin_out_d;
    logic             reject_q, reject_d;
    logic             jam_q, jam_d;
    logic [7:0]       coin_count_q, coin_count_d;

    logic [2:0]       sync1_q;
    logic [2:0]       s_q;                 // synchronised sensor vector {c, b, a}

    logic             one_hot;
    logic             lat_hi;
    logic             other_hi;
    logic [1:0]       lat_code;
    logic [CNT_W-1:0] cnt_inc;

    // Two-flop synchroniser on the raw, asynchronous sensor lines.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 3'b000;
            s_q     <= 3'b000;
        end else begin
            // NOTE: flops always take non-blocking assignments so every register
            // samples the pre-edge value of the one before it.
            sync1_q <= {sense_c, sense_b, sense_a};
            s_q     <= sync1_q;
        end
    end

    assign one_hot  = (s_q != 3'b000) && ((s_q & (s_q - 3'd1)) == 3'b000);
    assign lat_hi   = |(s_q & sel_q);
    assign other_hi = |(s_q & ~sel_q);
    // a (001) -> 01, b (010) -> 10, c (100) -> 11
    assign lat_code = {sel_q[2] | sel_q[1], sel_q[2] | sel_q[0]};
    assign cnt_inc  = cnt_q + CNT_ONE;

    // Next-state, counter and registered-output logic for the qualification FSM.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        coin_out_d   = 2'b00;
        reject_d     = 1'b0;
        coin_count_d = coin_count_q;

        case (state_q)
            S_IDLE: begin
                if (one_hot) begin
                    sel_d   = s_q;
                    cnt_d   = CNT_ONE;
                    state_d = S_QUAL;
                end else if (s_q != 3'b000) begin
                    reject_d = 1'b1;
                    state_d  = S_CLEAR;
                end
            end
            S_QUAL: begin
                if (!lat_hi) begin
                    state_d = S_IDLE;          // too short: silent glitch
                end else if (other_hi) begin
                    reject_d = 1'b1;
                    state_d  = S_CLEAR;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == DEB_LIM) state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                // Release is checked first so it beats a same-sample jam count;
                // another sensor rising as this one drops is a new coin, not an overlap.
                if (!lat_hi) begin
                    state_d = S_EMIT;
                    if (coin_count_q != 8'hFF) coin_count_d = coin_count_q + 8'd1;
                end else if (other_hi) begin
                    reject_d = 1'b1;
                    state_d  = S_CLEAR;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == JAM_LIM) begin
                        reject_d = 1'b1;
                        state_d  = S_JAM;
                    end
                end
            end
            S_EMIT: begin
                // Code is registered from the state, so it appears one cycle after EMIT is entered.
                coin_out_d = lat_code;
                cnt_d      = CNT_ONE;
                state_d    = S_GAP;
            end
            S_GAP: begin
                if (cnt_q == GAP_LIM) state_d = S_IDLE;
                else                  cnt_d   = cnt_inc;
            end
            S_CLEAR: begin
                if (s_q == 3'b000) state_d = S_IDLE;
            end
            S_JAM: begin
                if (s_q == 3'b000) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        jam_d = (state_d == S_JAM);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            sel_q        <= 3'b000;
            coin_out_q   <= 2'b00;
            reject_q     <= 1'b0;
            jam_q        <= 1'b0;
            coin_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            coin_out_q   <= coin_out_d;
            reject_q     <= reject_d;
            jam_q        <= jam_d;
            coin_count_q <= coin_count_d;
        end
    end

    assign coin_out   = coin_out_q;
    assign reject     = reject_q;
    assign jam        = jam_q;
    assign coin_count = coin_count_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench for coin_acceptor: expected codes are queued as coins are
// driven and compared when coin_out shows a code.
module tb_coin_acceptor;

    localparam int GAP = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] raw = 3'b000;   // {c, b, a}
    logic [1:0] coin_out;
    logic       reject;
    logic       jam;
    logic [7:0] coin_count;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [1:0] exp_q[$];
    int         exp_count = 0;
    int         rej_seen  = 0;
    int         rej_exp   = 0;

    always #5 clk = ~clk;

    coin_acceptor #(
        .DEBOUNCE (4),
        .MAX_PULSE(64),
        .GAP      (GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sense_a   (raw[0]),
        .sense_b   (raw[1]),
        .sense_c   (raw[2]),
        .coin_out  (coin_out),
        .reject    (reject),
        .jam       (jam),
        .coin_count(coin_count)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    endtask

    task automatic push(input logic [1:0] code);
        exp_q.push_back(code);
        if (exp_count < 255) exp_count++;
    endtask

    // Raw sensor(s) high for n sampling edges, starting at the next negedge.
    task automatic coin(input logic [2:0] mask, input int n);
        @(negedge clk);
        raw = mask;
        repeat (n) @(negedge clk);
        raw = 3'b000;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Output monitor: scoreboard pop, reject counting and code spacing.
    initial begin
        int zero_run;
        bit have_prev;
        logic [1:0] e;
        zero_run  = 0;
        have_prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (reject) rej_seen++;
            if (coin_out != 2'b00) begin
                if (have_prev) check("code_spacing", int'(zero_run >= GAP), 1);
                if (exp_q.size() == 0) begin
                    check("unexpected_code", coin_out, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("code", coin_out, e);
                end
                have_prev = 1'b1;
                zero_run  = 0;
            end else begin
                zero_run++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        idle(3);
        check("rst_coin_out", coin_out, 0);
        check("rst_reject", reject, 0);
        check("rst_jam", jam, 0);
        check("rst_count", coin_count, 0);
        rst = 1'b1;
        idle(3);

        // Clean A coin, exact emit latency: code only in the cycle after edge 3
        @(negedge clk);
        raw = 3'b001;
        repeat (6) @(negedge clk);
        raw = 3'b000;
        push(2'b01);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("emit_latency", coin_out, (i == 3) ? 1 : 0);
        end
        idle(10);
        check("a_count", coin_count, exp_count);
        check("a_no_reject", rej_seen, rej_exp);

        // 3-cycle B pulse is a glitch, 4-cycle qualifies
        coin(3'b010, 3);
        idle(20);
        check("short_count", coin_count, exp_count);
        check("short_no_reject", rej_seen, rej_exp);
        coin(3'b010, 4);
        push(2'b10);
        idle(20);
        check("b4_count", coin_count, exp_count);

        // C immediately followed by A: two codes, spaced
        @(negedge clk);
        raw = 3'b100;
        repeat (8) @(negedge clk);
        raw = 3'b001;
        push(2'b11);
        repeat (8) @(negedge clk);
        raw = 3'b000;
        push(2'b01);
        idle(20);
        check("ca_count", coin_count, exp_count);

        // A and B together: one reject, no code; then a clean B
        coin(3'b011, 5);
        rej_exp++;
        idle(10);
        check("overlap_reject", rej_seen, rej_exp);
        check("overlap_count", coin_count, exp_count);
        coin(3'b010, 5);
        push(2'b10);
        idle(20);
        check("after_overlap_count", coin_count, exp_count);

        // C held 100 cycles: jam at sample 64, no code on release
        @(negedge clk);
        raw = 3'b100;
        rej_exp++;
        repeat (60) @(posedge clk);
        #1;
        check("jam_before_limit", jam, 0);
        repeat (10) @(posedge clk);
        #1;
        check("jam_set", jam, 1);
        check("jam_reject", rej_seen, rej_exp);
        @(negedge clk);
        repeat (29) @(negedge clk);
        raw = 3'b000;
        idle(10);
        check("jam_cleared", jam, 0);
        check("jam_count", coin_count, exp_count);
        check("jam_reject_once", rej_seen, rej_exp);

        // Reset while a coin is held: discarded
        @(negedge clk);
        raw = 3'b001;
        repeat (8) @(negedge clk);
        rst = 1'b0;
        #1;
        exp_count = 0;
        check("midrst_coin_out", coin_out, 0);
        check("midrst_reject", reject, 0);
        check("midrst_jam", jam, 0);
        check("midrst_count", coin_count, 0);
        raw = 3'b000;
        idle(3);
        rst = 1'b1;
        idle(20);
        check("post_rst_count", coin_count, exp_count);

        // 256 coins: count saturates at 255
        for (int k = 0; k < 256; k++) begin
            coin(3'b001, 4);
            push(2'b01);
            idle(8);
        end
        idle(20);
        check("sat_count", coin_count, 255);
        check("sat_reject", rej_seen, rej_exp);
        check("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
